// File: rtl/mul_arbiter_pkg.sv
// Shared types and constants for the EX-stage multiplier arbiter.
// NTHREADS and WIDTH size every thread-indexed and data bus. MUL_LATENCY is the
// pipeline depth of the shared multiplier. Every user of the multiplier must see
// the same MUL_LATENCY value.
package mul_arbiter_pkg;

    localparam int NTHREADS    = 4;
    localparam int MUL_LATENCY = 3;
    localparam int WIDTH       = 32;
    localparam int TW          = $clog2(NTHREADS);

    typedef logic [TW-1:0]    thread_t;
    typedef logic [WIDTH-1:0] word_t;

    // Tag that travels beside an operation while it is inside the multiplier.
    typedef struct packed {
        logic    valid;
        thread_t thread;
    } mul_tag_t;

    // Returns the next round-robin start point after a grant to g.
    // NTHREADS is a power of two, so the modulo is a natural wrap.
    function automatic thread_t rr_next(input thread_t g);
        return g + thread_t'(1);
    endfunction

endpackage

// File: rtl/mul_arbiter_if.sv
// Bundle of thread-side, multiplier-side and writeback-side signals of the
// multiplier arbiter.
//   slave  : the arbiter. It takes requests, flushes and mul_result. It drives
//            grants, operands, responses and status.
//   master : the environment, meaning the threads, the multiplier and writeback.
interface mul_arbiter_if;
    import mul_arbiter_pkg::*;

    logic [NTHREADS-1:0]       req_valid;
    logic [NTHREADS*WIDTH-1:0] req_a;
    logic [NTHREADS*WIDTH-1:0] req_b;
    logic [NTHREADS-1:0]       req_grant;
    logic [NTHREADS-1:0]       flush;
    logic                      mul_valid;
    word_t                     mul_a;
    word_t                     mul_b;
    word_t                     mul_result;
    logic                      resp_valid;
    thread_t                   resp_thread;
    word_t                     resp_data;
    logic [NTHREADS-1:0]       busy;
    logic [TW:0]               inflight;

    modport slave (
        input  req_valid, req_a, req_b, flush, mul_result,
        output req_grant, mul_valid, mul_a, mul_b,
               resp_valid, resp_thread, resp_data, busy, inflight
    );

    modport master (
        output req_valid, req_a, req_b, flush, mul_result,
        input  req_grant, mul_valid, mul_a, mul_b,
               resp_valid, resp_thread, resp_data, busy, inflight
    );

endinterface

// File: rtl/mul_arbiter_rr_arbiter.sv
// Round-robin one-hot picker. The module is purely combinational.
// It scans i_ptr, i_ptr+1, ... (mod N) and picks the first set bit of i_elig.
// Ports:
//   i_elig  : eligible requesters
//   i_ptr   : index with the highest priority this cycle
//   o_grant : one-hot grant, which is zero when nothing is eligible
//   o_idx   : index of the granted requester
//   o_valid : set when any grant is made
// N must be a power of two.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_elig,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    logic [IW-1:0] w_cand;

    // Scan from the pointer and pick the first eligible index.
    always_comb begin
        o_grant = {N{1'b0}};
        o_idx   = {IW{1'b0}};
        o_valid = 1'b0;
        w_cand  = {IW{1'b0}};
        for (int k = 0; k < N; k++) begin
            w_cand = i_ptr + IW'(k);
            if (!o_valid && i_elig[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end else begin
                o_valid = o_valid;
            end
        end
        o_grant[o_idx] = o_valid;
    end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one pipelined multiplier among NTHREADS threads.
// Requests are arbitrated round-robin. The selected operands are registered
// into the multiplier. A {valid, thread} tag follows each operation through the
// multiplier latency, and the product comes back as a registered, thread-tagged
// writeback response.
// Each thread may have only one multiply outstanding. A per-thread flush kills
// the pending operation of that thread and any of its operations in flight.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous reset, active low
//   bus : mul_arbiter_if.slave. It carries requests, grants, flushes, the
//         multiplier operands and result, the writeback response, busy and
//         inflight.
module mul_arbiter
    import mul_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mul_arbiter_if.slave  bus
);

    logic [NTHREADS-1:0] w_elig;
    logic [NTHREADS-1:0] w_grant;
    thread_t             w_grant_idx;
    logic                w_grant_valid;

    thread_t             r_rr_ptr;
    logic [NTHREADS-1:0] r_busy;
    logic                r_mul_valid;
    thread_t             r_op_thread;
    word_t               r_mul_a;
    word_t               r_mul_b;
    mul_tag_t            r_tag [MUL_LATENCY];
    logic                r_resp_valid;
    thread_t             r_resp_thread;
    word_t               r_resp_data;
    logic [TW:0]         r_inflight;

    mul_tag_t            w_tag_nxt [MUL_LATENCY];
    logic                w_capture;
    logic [NTHREADS-1:0] w_resp_clr;
    logic [NTHREADS-1:0] w_busy_nxt;
    logic [TW:0]         w_inflight_nxt;

    // Eligibility is forced low while reset is asserted, so req_grant reads zero
    // during reset like every other output.
    assign w_elig = rst ? (bus.req_valid & ~r_busy & ~bus.flush) : {NTHREADS{1'b0}};

    rr_arbiter #(.N(NTHREADS)) u_rr (
        .i_elig  (w_elig),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_grant_idx),
        .o_valid (w_grant_valid)
    );

    // Next-state logic for the tag pipeline, busy and inflight.
    // A flush drops the thread's tags as they advance, so a killed operation
    // never reaches the capture stage and never matches a newer operation.
    always_comb begin
        w_tag_nxt[0].valid  = r_mul_valid & ~bus.flush[r_op_thread];
        w_tag_nxt[0].thread = r_op_thread;
        for (int k = 1; k < MUL_LATENCY; k++) begin
            w_tag_nxt[k].valid  = r_tag[k-1].valid & ~bus.flush[r_tag[k-1].thread];
            w_tag_nxt[k].thread = r_tag[k-1].thread;
        end

        // The last tag lines up with mul_result. A flush in this same cycle still
        // suppresses the response.
        w_capture  = r_tag[MUL_LATENCY-1].valid & ~bus.flush[r_tag[MUL_LATENCY-1].thread];
        w_resp_clr = {NTHREADS{1'b0}};
        if (w_capture) begin
            w_resp_clr[r_tag[MUL_LATENCY-1].thread] = 1'b1;
        end else begin
            w_resp_clr = {NTHREADS{1'b0}};
        end

        // A grant never targets a busy or flushed thread, so the set and clear
        // terms never hit the same bit.
        w_busy_nxt = (r_busy & ~w_resp_clr & ~bus.flush) | w_grant;

        w_inflight_nxt = {{TW{1'b0}}, w_grant_valid};
        for (int k = 0; k < MUL_LATENCY; k++) begin
            w_inflight_nxt = w_inflight_nxt + {{TW{1'b0}}, w_tag_nxt[k].valid};
        end
    end

    // State registers: pointer, operand stage, tag pipeline, response and status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr      <= {TW{1'b0}};
            r_busy        <= {NTHREADS{1'b0}};
            r_mul_valid   <= 1'b0;
            r_op_thread   <= {TW{1'b0}};
            r_mul_a       <= {WIDTH{1'b0}};
            r_mul_b       <= {WIDTH{1'b0}};
            for (int k = 0; k < MUL_LATENCY; k++) begin
                r_tag[k] <= '{valid: 1'b0, thread: {TW{1'b0}}};
            end
            r_resp_valid  <= 1'b0;
            r_resp_thread <= {TW{1'b0}};
            r_resp_data   <= {WIDTH{1'b0}};
            r_inflight    <= {(TW+1){1'b0}};
        end else begin
            r_mul_valid <= w_grant_valid;
            if (w_grant_valid) begin
                r_rr_ptr    <= rr_next(w_grant_idx);
                r_op_thread <= w_grant_idx;
                r_mul_a     <= bus.req_a[w_grant_idx*WIDTH +: WIDTH];
                r_mul_b     <= bus.req_b[w_grant_idx*WIDTH +: WIDTH];
            end else begin
                r_rr_ptr    <= r_rr_ptr;
                r_op_thread <= r_op_thread;
                r_mul_a     <= r_mul_a;
                r_mul_b     <= r_mul_b;
            end
            for (int k = 0; k < MUL_LATENCY; k++) begin
                r_tag[k] <= w_tag_nxt[k];
            end
            r_resp_valid <= w_capture;
            if (w_capture) begin
                r_resp_thread <= r_tag[MUL_LATENCY-1].thread;
                r_resp_data   <= bus.mul_result;
            end else begin
                r_resp_thread <= r_resp_thread;
                r_resp_data   <= r_resp_data;
            end
            r_busy     <= w_busy_nxt;
            r_inflight <= w_inflight_nxt;
        end
    end

    assign bus.req_grant   = w_grant;
    assign bus.mul_valid   = r_mul_valid;
    assign bus.mul_a       = r_mul_a;
    assign bus.mul_b       = r_mul_b;
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_thread = r_resp_thread;
    assign bus.resp_data   = r_resp_data;
    assign bus.busy        = r_busy;
    assign bus.inflight    = r_inflight;

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter. The bench runs directed scenarios first
// and randomized traffic afterwards, and checks both against a per-thread
// reference model.
module tb_mul_arbiter;
    import mul_arbiter_pkg::*;

    localparam int L = MUL_LATENCY;

    typedef struct {
        int               cyc;
        int               thr;
        logic [WIDTH-1:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mul_arbiter_if bus();

    mul_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [WIDTH-1:0] opa [NTHREADS];
    logic [WIDTH-1:0] opb [NTHREADS];

    // Behavioural multiplier: the products are due MUL_LATENCY cycles later.
    logic [WIDTH-1:0] mres   [16];
    bit               mres_v [16];

    // Reference model state.
    bit               m_has_op [NTHREADS];
    int               m_gcyc   [NTHREADS];
    int               m_ptr;
    bit               m_issue_v;
    logic [WIDTH-1:0] m_issue_a;
    logic [WIDTH-1:0] m_issue_b;
    rsp_t             rq [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < NTHREADS; t++) begin
            m_has_op[t] = 1'b0;
            m_gcyc[t]   = 0;
        end
        for (int i = 0; i < 16; i++) mres_v[i] = 1'b0;
        m_ptr     = 0;
        m_issue_v = 1'b0;
        m_issue_a = '0;
        m_issue_b = '0;
        rq.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_grant"},    64'(bus.req_grant),   64'd0);
        check_eq({tag, "_mvalid"},   64'(bus.mul_valid),   64'd0);
        check_eq({tag, "_mul_a"},    64'(bus.mul_a),       64'd0);
        check_eq({tag, "_mul_b"},    64'(bus.mul_b),       64'd0);
        check_eq({tag, "_rvalid"},   64'(bus.resp_valid),  64'd0);
        check_eq({tag, "_rthread"},  64'(bus.resp_thread), 64'd0);
        check_eq({tag, "_rdata"},    64'(bus.resp_data),   64'd0);
        check_eq({tag, "_busy"},     64'(bus.busy),        64'd0);
        check_eq({tag, "_inflight"}, 64'(bus.inflight),    64'd0);
    endtask

    task automatic rand_ops();
        for (int t = 0; t < NTHREADS; t++) begin
            opa[t] = $urandom();
            opb[t] = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 15)) : $urandom();
        end
    endtask

    // One clock cycle: drive the inputs, compare against the model, then advance the model.
    task automatic run_cycle(input logic [NTHREADS-1:0] rv, input logic [NTHREADS-1:0] fl);
        logic [NTHREADS-1:0] exp_busy;
        logic [NTHREADS-1:0] elig;
        logic [NTHREADS-1:0] exp_grant;
        int                  g;
        int                  idx;
        int                  exp_inf;
        bit                  exp_rv;
        rsp_t                keep [$];

        @(negedge clk);
        bus.req_valid = rv;
        bus.flush     = fl;
        for (int t = 0; t < NTHREADS; t++) begin
            bus.req_a[t*WIDTH +: WIDTH] = opa[t];
            bus.req_b[t*WIDTH +: WIDTH] = opb[t];
        end
        bus.mul_result = mres_v[cyc % 16] ? mres[cyc % 16] : $urandom();
        #1;

        exp_inf = 0;
        for (int t = 0; t < NTHREADS; t++) begin
            exp_busy[t] = m_has_op[t];
            exp_inf += int'(m_has_op[t]);
        end
        elig = rv & ~exp_busy & ~fl;
        g = -1;
        for (int k = 0; k < NTHREADS; k++) begin
            idx = (m_ptr + k) % NTHREADS;
            if (g < 0 && elig[idx]) g = idx;
        end
        exp_grant = '0;
        if (g >= 0) exp_grant[g] = 1'b1;
        exp_rv = (rq.size() > 0) && (rq[0].cyc == cyc);

        check_eq("grant",    64'(bus.req_grant), 64'(exp_grant));
        check_eq("busy",     64'(bus.busy),      64'(exp_busy));
        check_eq("inflight", 64'(bus.inflight),  64'(exp_inf));
        check_eq("mvalid",   64'(bus.mul_valid), 64'(m_issue_v));
        check_eq("mul_a",    64'(bus.mul_a),     64'(m_issue_a));
        check_eq("mul_b",    64'(bus.mul_b),     64'(m_issue_b));
        check_eq("rvalid",   64'(bus.resp_valid), 64'(exp_rv));
        if (exp_rv) begin
            check_eq("rthread", 64'(bus.resp_thread), 64'(rq[0].thr));
            check_eq("rdata",   64'(bus.resp_data),   64'(rq[0].data));
            void'(rq.pop_front());
        end

        mres_v[cyc % 16] = 1'b0;
        if (bus.mul_valid === 1'b1) begin
            mres[(cyc + L) % 16]   = bus.mul_a * bus.mul_b;
            mres_v[(cyc + L) % 16] = 1'b1;
        end

        // A flush kills the thread's live operation and any response not yet delivered.
        for (int t = 0; t < NTHREADS; t++) begin
            if (fl[t]) begin
                m_has_op[t] = 1'b0;
                keep.delete();
                foreach (rq[i]) if (!(rq[i].thr == t && rq[i].cyc > cyc)) keep.push_back(rq[i]);
                rq = keep;
            end
            if (m_has_op[t] && cyc == m_gcyc[t] + 1 + L) m_has_op[t] = 1'b0;
        end
        m_issue_v = (g >= 0);
        if (g >= 0) begin
            m_has_op[g] = 1'b1;
            m_gcyc[g]   = cyc;
            m_issue_a   = opa[g];
            m_issue_b   = opb[g];
            rq.push_back('{cyc: cyc + 2 + L, thr: g, data: opa[g] * opb[g]});
            m_ptr = (g + 1) % NTHREADS;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle('0, '0);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        bus.req_valid = '1;
        #1;
        check_all_zero("async_rst");
        bus.req_valid = '0;
        bus.flush     = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.flush      = '0;
        bus.mul_result = '0;
        for (int t = 0; t < NTHREADS; t++) begin
            opa[t] = '0;
            opb[t] = '0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // All threads request at once, starting from pointer 0.
        for (int i = 0; i < 10; i++) begin
            rand_ops();
            run_cycle('1, '0);
        end
        idle(8);

        // Single operation: thread 2 computes 7*6.
        opa[2] = 32'd7;
        opb[2] = 32'd6;
        run_cycle(4'b0100, '0);
        idle(7);

        // Thread 1 holds its request alone and may have only one op outstanding.
        rand_ops();
        for (int i = 0; i < 10; i++) run_cycle(4'b0010, '0);
        idle(6);

        // Thread 3 is flushed while its op is in flight.
        rand_ops();
        run_cycle(4'b1000, '0);
        run_cycle('0, '0);
        run_cycle('0, 4'b1000);
        idle(6);

        // A flush and a request from the same thread in the same cycle.
        rand_ops();
        run_cycle(4'b0011, 4'b0001);
        idle(6);

        // Asynchronous reset arrives with three ops in flight.
        rand_ops();
        for (int i = 0; i < 3; i++) run_cycle(4'b0111, '0);
        async_reset();
        idle(10);
        rand_ops();
        run_cycle('1, '0);
        idle(8);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 1500; i++) begin
            logic [NTHREADS-1:0] rv;
            logic [NTHREADS-1:0] fl;
            rand_ops();
            rv = NTHREADS'($urandom());
            for (int t = 0; t < NTHREADS; t++) fl[t] = ($urandom_range(0, 9) == 0);
            run_cycle(rv, fl);
        end
        idle(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
